sha256_block_ctrl: RTL
======================

SHA256_BLOCK_CTRL -- requirements
Module: sha256_block_ctrl

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 64, the number of compression rounds per block.
REQ-002 The block SHALL have parameter WORD_SIZE, default 32, the message word width.
REQ-003 The block SHALL have parameter BLK_WORDS, default 16, the number of words per message block.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 abort  in  1  synchronous clear of the message in progress.
REQ-008 in_valid  in  1  a message word is offered.
REQ-009 in_ready  out  1  the block accepts a word.
REQ-010 in_data  in  WORD_SIZE  message word, forwarded as dp_w_data.
REQ-011 in_first  in  1  first block of a message; sampled on word 0 only.
REQ-012 in_last  in  1  last block of a message; sampled on word BLK_WORDS-1 only.
REQ-013 dp_init  out  1  datapath loads the initial hash values into the chaining registers.
REQ-014 dp_w_load  out  1  datapath writes dp_w_data into schedule slot dp_w_idx.
REQ-015 dp_w_idx  out  4  schedule slot index.
REQ-016 dp_w_data  out  WORD_SIZE  in_data, passed through combinationally.
REQ-017 dp_round_en  out  1  datapath executes one round.
REQ-018 dp_round_idx  out  6  round index, used to select K.
REQ-019 dp_w_sel  out  1  0: W comes from a loaded word; 1: W comes from the sigma0/sigma1 expansion.
REQ-020 dp_accum  out  1  datapath adds the working variables a..h into the chaining registers.
REQ-021 digest_valid  out  1  the chaining registers hold the final digest.
REQ-022 digest_ready  in  1  the consumer takes the digest.
REQ-023 busy  out  1  the block is not in IDLE.
REQ-024 orphan_err  out  1  one-cycle pulse flagging a continuation block with no message open.

Function
REQ-025 States SHALL be IDLE, LOAD, ROUND, ACCUM and DONE, with counters word_cnt[3:0] and round_cnt[5:0] and a msg_active flag.
REQ-026 in_ready SHALL be 1 in IDLE and LOAD, and 0 in every other state.
REQ-027 A handshake SHALL occur when in_valid and in_ready are both 1; on each handshake: dp_w_load=1, dp_w_idx=word_cnt, then word_cnt increments.
REQ-028 On a handshake in IDLE, dp_init SHALL be 1 in that cycle if in_first=1 or msg_active=0; msg_active is then set to 1 and the state goes to LOAD.
REQ-029 On a handshake in IDLE with in_first=0 and msg_active=0, orphan_err SHALL pulse for that cycle and the word SHALL be processed as a first block.
REQ-030 On a handshake with word_cnt=BLK_WORDS-1, in_last SHALL be captured, word_cnt SHALL wrap to 0 and the state SHALL go to ROUND with round_cnt=0.
REQ-031 word_cnt SHALL not change in cycles without a handshake; gaps in in_valid are legal.
REQ-032 In ROUND, dp_round_en=1 and dp_round_idx=round_cnt every cycle, and dp_w_sel=(round_cnt>=16).
REQ-033 ROUND SHALL last exactly ROUNDS cycles; at round_cnt=ROUNDS-1 the state goes to ACCUM.
REQ-034 ACCUM SHALL last one cycle with dp_accum=1; it then goes to DONE if the captured last flag is set, otherwise to IDLE with msg_active kept at 1.
REQ-035 In DONE, digest_valid SHALL be 1 and held until digest_ready=1; that cycle is the handshake, after which msg_active clears and the state goes to IDLE.
REQ-036 Latency SHALL be fixed: with the final-word handshake in cycle T, round_en is 1 in cycles T+1..T+64, dp_accum is 1 in T+65 and digest_valid first rises in T+66.
REQ-037 abort SHALL override every other event: next cycle the state is IDLE, counters are 0 and msg_active is 0; a dp_accum, digest or init already due in that cycle is suppressed.
REQ-038 All datapath strobes SHALL be mutually exclusive, except that dp_init and dp_w_load coincide on word 0.

Reset
REQ-039 While rst_n=0, the state SHALL be IDLE, word_cnt, round_cnt and msg_active SHALL be 0, every strobe SHALL be 0, digest_valid=0, busy=0, in_ready=1 and orphan_err=0.
REQ-040 Reset asserted mid-operation SHALL discard the block in progress with no dp_accum pulse.

Verification
REQ-041 "abc" block (61626380, 14 x 00000000, 00000018), first=last=1 -> dp_init once, 16 loads at idx 0-15, 64 rounds with w_sel=0 for idx 0-15, one accum, digest_valid at T+66; with a reference datapath the digest is ba7816bf...f20015ad.
REQ-042 Two-block message (first=1 then first=0, last=1) -> exactly one dp_init, two dp_accum pulses, and digest_valid only after the second block.
REQ-043 digest_ready held low for 10 cycles -> digest_valid and busy stay 1 and in_ready stays 0; in_ready=1 on the cycle after the handshake.
REQ-044 in_valid toggled every other cycle during LOAD -> exactly 16 loads with contiguous idx 0-15, and ROUND entered after the 16th handshake.
REQ-045 abort at round_cnt=30 -> IDLE next cycle with no accum; rst_n pulsed low mid-LOAD -> all reset values immediately.
REQ-046 first=0 with no message open -> orphan_err pulses once and dp_init is still asserted.

Source files
------------

// File: rtl/sha256_block_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_block_ctrl
//  Purpose  : Sequencer for a SHA-256 compression datapath. It loads BLK_WORDS
//             message words into the schedule, runs ROUNDS compression rounds,
//             accumulates into the chaining registers, and presents the digest
//             once the last block of a message has been processed.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             abort            - synchronous clear of the message in progress
//             in_valid/in_ready/in_data/in_first/in_last - word input stream
//             dp_init, dp_w_load, dp_w_idx, dp_w_data, dp_round_en,
//             dp_round_idx, dp_w_sel, dp_accum          - datapath controls
//             digest_valid/digest_ready                  - digest handshake
//             busy, orphan_err                           - status
//  Revision : 1.0  initial release
// ============================================================================
module sha256_block_ctrl #(
    parameter int ROUNDS    = 64,
    parameter int WORD_SIZE = 32,
    parameter int BLK_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 dp_init,
    output logic                 dp_w_load,
    output logic [3:0]           dp_w_idx,
    output logic [WORD_SIZE-1:0] dp_w_data,
    output logic                 dp_round_en,
    output logic [5:0]           dp_round_idx,
    output logic                 dp_w_sel,
    output logic                 dp_accum,
    output logic                 digest_valid,
    input  logic                 digest_ready,
    output logic                 busy,
    output logic                 orphan_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] C_LAST_WORD  = 4'(BLK_WORDS - 1);
    localparam logic [5:0] C_LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [5:0] C_EXP_START  = 6'd16;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_word_cnt;
    logic [3:0] w_word_cnt_nxt;
    logic [5:0] r_round_cnt;
    logic [5:0] w_round_cnt_nxt;
    logic       r_msg_active;
    logic       w_msg_active_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_hs;

    assign in_ready     = (r_state == IDLE) || (r_state == LOAD);
    // rst_n gates the handshake so no strobe can leak out while reset is held
    // with in_valid high (in_ready is 1 during reset).
    assign w_hs         = in_valid && in_ready && rst_n;
    assign dp_w_idx     = r_word_cnt;
    assign dp_w_data    = in_data;
    assign dp_round_idx = r_round_cnt;
    assign busy         = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word_cnt   <= 4'd0;
            r_round_cnt  <= 6'd0;
            r_msg_active <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_round_cnt  <= w_round_cnt_nxt;
            r_msg_active <= w_msg_active_nxt;
            r_last       <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_word_cnt_nxt   = r_word_cnt;
        w_round_cnt_nxt  = r_round_cnt;
        w_msg_active_nxt = r_msg_active;
        w_last_nxt       = r_last;
        dp_init          = 1'b0;
        dp_w_load        = 1'b0;
        dp_round_en      = 1'b0;
        dp_w_sel         = 1'b0;
        dp_accum         = 1'b0;
        digest_valid     = 1'b0;
        orphan_err       = 1'b0;

        case (r_state)
            IDLE, LOAD: begin
                if (w_hs) begin
                    dp_w_load = 1'b1;
                    if (r_state == IDLE) begin
                        // A continuation block with nothing open is flagged
                        // and then treated as the start of a new message.
                        dp_init          = in_first || !r_msg_active;
                        orphan_err       = !in_first && !r_msg_active;
                        w_msg_active_nxt = 1'b1;
                        w_state_nxt      = LOAD;
                    end
                    if (r_word_cnt == C_LAST_WORD) begin
                        w_last_nxt      = in_last;
                        w_word_cnt_nxt  = 4'd0;
                        w_round_cnt_nxt = 6'd0;
                        w_state_nxt     = ROUND;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 4'd1;
                    end
                end
            end
            ROUND: begin
                dp_round_en = 1'b1;
                dp_w_sel    = (r_round_cnt >= C_EXP_START);
                if (r_round_cnt == C_LAST_ROUND) begin
                    w_round_cnt_nxt = 6'd0;
                    w_state_nxt     = ACCUM;
                end else begin
                    w_round_cnt_nxt = r_round_cnt + 6'd1;
                end
            end
            ACCUM: begin
                dp_accum    = 1'b1;
                w_state_nxt = r_last ? DONE : IDLE;
            end
            DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    w_msg_active_nxt = 1'b0;
                    w_last_nxt       = 1'b0;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything, including strobes already due this cycle.
        if (abort) begin
            w_state_nxt      = IDLE;
            w_word_cnt_nxt   = 4'd0;
            w_round_cnt_nxt  = 6'd0;
            w_msg_active_nxt = 1'b0;
            w_last_nxt       = 1'b0;
            dp_init          = 1'b0;
            dp_accum         = 1'b0;
            digest_valid     = 1'b0;
            orphan_err       = 1'b0;
        end
    end

endmodule
`default_nettype wire
